// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: sequencer state encoding,
// the ms-to-cycle conversion and timer sizing helpers.
package freq_meter_pkg;

  localparam int unsigned DEF_CLK_HZ = 50_000_000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_GATE  = 3'd2,
    ST_LATCH = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  function automatic int unsigned ms_to_cyc(input int unsigned clk_hz, input int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

  // Timer width able to hold 0..cyc-1; never narrower than one bit.
  function automatic int unsigned tmr_width(input int unsigned cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// Control/result bundle between the measurement sequencer and its user
// (request, signal under test, result handshake).
interface freq_gate_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             cont;
  logic             sig_in;
  logic             ack;
  logic             gate;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             valid;

  modport master (
    output start, cont, sig_in, ack,
    input  gate, busy, count, ovf, valid
  );

  modport slave (
    input  start, cont, sig_in, ack,
    output gate, busy, count, ovf, valid
  );
endinterface

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Output pulse is one clk wide, three cycles after the input transition.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [1:0] sync_reg;
  logic       prev_reg;
  logic       rise_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b00;
      prev_reg <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], din};
      prev_reg <= sync_reg[1];
      rise_reg <= sync_reg[1] & ~prev_reg;
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/freq_gate_ctrl.sv
// Frequency meter sequencer: clear, count synchronized rising edges for an
// exact gate window, latch the result, hold for display, optionally repeat.
module freq_gate_ctrl
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ  = DEF_CLK_HZ,
  parameter int unsigned GATE_MS = 1000,
  parameter int unsigned HOLD_MS = 1000,
  parameter int unsigned CNT_W   = 32
) (
  input logic             sysclk,
  input logic             reset,
  freq_gate_ctrl_if.slave bus
);

  localparam int unsigned GATE_CYC = ms_to_cyc(CLK_HZ, GATE_MS);
  localparam int unsigned HOLD_CYC = ms_to_cyc(CLK_HZ, HOLD_MS);
  localparam int unsigned GW       = tmr_width(GATE_CYC);
  localparam int unsigned HW       = tmr_width(HOLD_CYC);

  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYC - 1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_reg, state_next;
  logic [GW-1:0]    gate_tmr_reg, gate_tmr_next;
  logic [HW-1:0]    hold_tmr_reg, hold_tmr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ovf_flag_reg, ovf_flag_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             ovf_reg, ovf_next;
  logic             valid_reg, valid_next;
  logic             gate_reg, gate_next;
  logic             busy_reg, busy_next;
  logic             rise;

  edge_sync u_edge_sync (
    .clk  (sysclk),
    .rst  (reset),
    .din  (bus.sig_in),
    .rise (rise)
  );

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      gate_tmr_reg <= '0;
      hold_tmr_reg <= '0;
      cnt_reg      <= '0;
      ovf_flag_reg <= 1'b0;
      count_reg    <= '0;
      ovf_reg      <= 1'b0;
      valid_reg    <= 1'b0;
      gate_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gate_tmr_reg <= gate_tmr_next;
      hold_tmr_reg <= hold_tmr_next;
      cnt_reg      <= cnt_next;
      ovf_flag_reg <= ovf_flag_next;
      count_reg    <= count_next;
      ovf_reg      <= ovf_next;
      valid_reg    <= valid_next;
      gate_reg     <= gate_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    gate_tmr_next = gate_tmr_reg;
    hold_tmr_next = hold_tmr_reg;
    cnt_next      = cnt_reg;
    ovf_flag_next = ovf_flag_reg;
    count_next    = count_reg;
    ovf_next      = ovf_reg;
    valid_next    = valid_reg;

    // Consumer ack; a LATCH in the same cycle overrides this below.
    if (bus.ack && valid_reg) begin
      valid_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        if (bus.start || bus.cont) begin
          state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        cnt_next      = '0;
        ovf_flag_next = 1'b0;
        gate_tmr_next = '0;
        state_next    = ST_GATE;
      end
      ST_GATE: begin
        if (rise && gate_reg) begin
          if (cnt_reg == CNT_MAX) begin
            ovf_flag_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        if (gate_tmr_reg == GATE_LAST) begin
          state_next = ST_LATCH;
        end else begin
          gate_tmr_next = gate_tmr_reg + 1'b1;
        end
      end
      ST_LATCH: begin
        count_next    = cnt_reg;
        ovf_next      = ovf_flag_reg;
        valid_next    = 1'b1;
        hold_tmr_next = '0;
        if (HOLD_CYC == 0) begin
          state_next = bus.cont ? ST_CLEAR : ST_IDLE;
        end else begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_tmr_reg == HOLD_LAST) begin
          state_next = bus.cont ? ST_CLEAR : ST_IDLE;
        end else begin
          hold_tmr_next = hold_tmr_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Flopped from the next state so gate/busy line up exactly with the state.
    gate_next = (state_next == ST_GATE);
    busy_next = (state_next != ST_IDLE);
  end

  assign bus.gate  = gate_reg;
  assign bus.busy  = busy_reg;
  assign bus.count = count_reg;
  assign bus.ovf   = ovf_reg;
  assign bus.valid = valid_reg;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl: CLK_HZ=1000, 10-cycle gate, 5-cycle hold,
// plus a 3-bit, 20-cycle-gate instance for the saturation case.
module tb_freq_gate_ctrl;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic start  = 1'b0;
  logic cont   = 1'b0;
  logic ack    = 1'b0;
  logic s_start = 1'b0;
  logic tog_en = 1'b0;
  logic sig    = 1'b0;
  int   cyc    = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  freq_gate_ctrl_if #(.CNT_W(16)) bus ();
  freq_gate_ctrl_if #(.CNT_W(3))  sbus ();

  assign bus.start   = start;
  assign bus.cont    = cont;
  assign bus.sig_in  = sig;
  assign bus.ack     = ack;
  assign sbus.start  = s_start;
  assign sbus.cont   = 1'b0;
  assign sbus.sig_in = sig;
  assign sbus.ack    = 1'b0;

  freq_gate_ctrl #(.CLK_HZ(1000), .GATE_MS(10), .HOLD_MS(5), .CNT_W(16)) dut (
    .sysclk (clk),
    .reset  (rst),
    .bus    (bus)
  );

  freq_gate_ctrl #(.CLK_HZ(1000), .GATE_MS(20), .HOLD_MS(5), .CNT_W(3)) dut_sat (
    .sysclk (clk),
    .reset  (rst),
    .bus    (sbus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // sig_in toggles every cycle when enabled, otherwise parks low.
  always @(negedge clk) begin
    if (tog_en) sig = ~sig;
    else        sig = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits until gate equals lvl; returns cycles waited (bound on timeout).
  task automatic wait_gate(input logic lvl, output int n);
    n = 0;
    while (bus.gate !== lvl && n < 60) begin
      tick();
      n++;
    end
  endtask

  // Start pulse, then count gate-high cycles; returns in the LATCH cycle.
  task automatic measure(output int glen);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    glen = 0;
    while (bus.gate === 1'b1 && glen < 60) begin
      glen++;
      tick();
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n, t0, t1, t2;
    #1;
    check("rst_gate",  bus.gate,  0);
    check("rst_busy",  bus.busy,  0);
    check("rst_valid", bus.valid, 0);
    check("rst_count", bus.count, 0);
    check("rst_ovf",   bus.ovf,   0);
    repeat (3) tick();
    rst = 1'b0;
    tog_en = 1'b1;
    repeat (6) tick();

    // 1: toggling input, single start
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy_clear", bus.busy, 1);
    check("t1_gate_clear", bus.gate, 0);
    tick();
    n = 0;
    while (bus.gate === 1'b1 && n < 60) begin
      n++;
      tick();
    end
    check("t1_gate_len", n, 10);
    check("t1_valid_in_latch", bus.valid, 0);
    tick();
    check("t1_valid", bus.valid, 1);
    check("t1_count", bus.count, 5);
    check("t1_ovf",   bus.ovf,   0);
    wait_idle(n);
    check("t1_hold_len", n, 5);

    // 2: quiet input, then ack
    tog_en = 1'b0;
    repeat (5) tick();
    measure(n);
    check("t2_gate_len", n, 10);
    tick();
    check("t2_count", bus.count, 0);
    check("t2_ovf",   bus.ovf,   0);
    check("t2_valid", bus.valid, 1);
    wait_idle(n);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t2_ack_clears", bus.valid, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t2_ack_idle", bus.valid, 0);

    // 3: saturation on the 3-bit instance
    tog_en = 1'b1;
    repeat (6) tick();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    n = 0;
    while (sbus.busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("t3_sat_count", sbus.count, 7);
    check("t3_sat_ovf",   sbus.ovf,   1);
    check("t3_sat_valid", sbus.valid, 1);
    tog_en = 1'b0;
    repeat (5) tick();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    n = 0;
    while (sbus.busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("t3_quiet_count", sbus.count, 0);
    check("t3_quiet_ovf",   sbus.ovf,   0);

    // 4: continuous mode, no ack
    tog_en = 1'b1;
    repeat (6) tick();
    cont = 1'b1;
    wait_gate(1'b1, n);
    t0 = cyc;
    wait_gate(1'b0, n);
    tick();
    check("t4_w1_count", bus.count, 5);
    check("t4_w1_valid", bus.valid, 1);
    tog_en = 1'b0;
    wait_gate(1'b1, n);
    t1 = cyc;
    check("t4_period_a", t1 - t0, 17);
    wait_gate(1'b0, n);
    tick();
    check("t4_w2_count", bus.count, 0);
    check("t4_w2_valid", bus.valid, 1);
    tog_en = 1'b1;
    wait_gate(1'b1, n);
    t2 = cyc;
    check("t4_period_b", t2 - t1, 17);
    repeat (3) tick();
    cont = 1'b0;
    wait_gate(1'b0, n);
    tick();
    check("t4_w3_count", bus.count, 5);
    check("t4_w3_valid", bus.valid, 1);
    wait_idle(n);
    check("t4_hold_len", n, 5);
    n = 0;
    repeat (30) begin
      tick();
      if (bus.gate === 1'b1) n++;
    end
    check("t4_no_restart", n, 0);

    // 5: async reset mid-gate
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    repeat (3) tick();
    check("t5_gate_before", bus.gate, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_gate",  bus.gate,  0);
    check("t5_rst_busy",  bus.busy,  0);
    check("t5_rst_valid", bus.valid, 0);
    check("t5_rst_count", bus.count, 0);
    check("t5_rst_ovf",   bus.ovf,   0);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    measure(n);
    check("t5_gate_len", n, 10);
    tick();
    check("t5_count", bus.count, 5);
    check("t5_valid", bus.valid, 1);
    wait_idle(n);

    // 6: ack coincident with LATCH, start during HOLD
    tog_en = 1'b0;
    repeat (5) tick();
    measure(n);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t6_valid_latch_wins", bus.valid, 1);
    check("t6_new_count", bus.count, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(n);
    check("t6_busy_idle", bus.busy, 0);
    n = 0;
    repeat (20) begin
      tick();
      if (bus.busy === 1'b1) n++;
    end
    check("t6_start_ignored", n, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
